mul_div_unit: RTL

//  Iterative MIPS HI/LO multiply/divide unit in the EX stage, directly downstream of the register file.

---
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS HI/LO multiply/divide unit (33-cycle MULT/MULTU/DIV/DIVU)
// Define MDU_DIV_EN to build the DIV/DIVU datapath; without it divide requests are ignored.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               neg_q, neg_d;

   logic               sa, sb, start_ok;
   logic [WIDTH-1:0]   mag_a, mag_b, opnd_init, hi_res, lo_res;
   logic [2*WIDTH-1:0] acc_init, acc_step, mul_step, prod_fix;
   logic [WIDTH:0]     add_sum;

   assign sa    = ~op[0] & a[WIDTH-1];
   assign sb    = ~op[0] & b[WIDTH-1];
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;

   // Multiply: low half of acc holds the multiplier, consumed LSB first while the product shifts in.
   assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_step = {add_sum, acc_q[WIDTH-1:1]};
   assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
   logic               is_div_q, is_div_d, sa_q, sa_d, div0_q, div0_d;
   logic [WIDTH:0]     shl, diff;
   logic [WIDTH-1:0]   quo_v, rem_v;
   logic [2*WIDTH-1:0] div_step;

   // Divide: acc = {remainder, dividend/quotient}; quotient bits enter at the LSB.
   assign shl      = acc_q[2*WIDTH-1:WIDTH-1];
   assign diff     = shl - {1'b0, opnd_q};
   assign div_step = diff[WIDTH] ? {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign quo_v    = acc_q[WIDTH-1:0];
   assign rem_v    = acc_q[2*WIDTH-1:WIDTH];

   assign start_ok  = start;
   assign acc_init  = op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
   assign opnd_init = op[1] ? mag_b : mag_a;
   assign acc_step  = is_div_q ? div_step : mul_step;
   assign hi_res    = is_div_q ? (sa_q ? -rem_v : rem_v) : prod_fix[2*WIDTH-1:WIDTH];
   assign lo_res    = is_div_q ? (div0_q ? '1 : (neg_q ? -quo_v : quo_v)) : prod_fix[WIDTH-1:0];

   assign is_div_d = (state_q == IDLE && start_ok) ? op[1]     : is_div_q;
   assign sa_d     = (state_q == IDLE && start_ok) ? sa        : sa_q;
   assign div0_d   = (state_q == IDLE && start_ok) ? (b == '0) : div0_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         div0_q   <= div0_d;
      end
   end
`else
   assign start_ok  = start & ~op[1];
   assign acc_init  = {{WIDTH{1'b0}}, mag_b};
   assign opnd_init = mag_a;
   assign acc_step  = mul_step;
   assign hi_res    = prod_fix[2*WIDTH-1:WIDTH];
   assign lo_res    = prod_fix[WIDTH-1:0];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = RUN;
               cnt_d   = '0;
               acc_d   = acc_init;
               opnd_d  = opnd_init;
               neg_d   = sa ^ sb;
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITER - 1)) state_d = FIX;
         end
         FIX: begin
            hi_d    = hi_res;
            lo_d    = lo_res;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule
